// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block: default 640x480 timing,
// FSM state encoding, field widths and the write-port record.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;

  localparam int RGB_W  = 24;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int LCLK_W = 12;
  localparam int ERR_W  = 8;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic             en;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] data;
  } vga_wr_t;

  // Saturating add of up to two error events to the error counter.
  function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Sync edge detector shared by the hsync and vsync inputs: registers the
// sync pin and flags the transition into its asserted level.
module vga_sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic act,
  output logic start
);

  logic s_q, s_qq;

  // Input register plus one delayed copy; both idle at the deasserted level
  // so reset release never fakes a sync start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q  <= ~POL;
      s_qq <= ~POL;
    end else begin
      s_q  <= sync_in;
      s_qq <= s_q;
    end
  end

  assign act   = (s_q == POL);
  assign start = act && (s_qq != POL);

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync/blank_n,
// trains on frame geometry and, once locked, emits a pixel write port.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank_n,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [X_W-1:0]    wr_x,
  output logic [Y_W-1:0]    wr_y,
  output logic [RGB_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic [LCLK_W-1:0] line_clks,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [X_W-1:0] H_ACT_X = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_ACT_Y = Y_W'(V_ACTIVE);

  logic              hs_act, hs_start, vs_act, vs_start;
  logic              v_q;
  logic [RGB_W-1:0]  rgb_q;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              line_act, line_bad;
  logic [LCLK_W-1:0] clk_cnt;
  vga_state_e        state;
  vga_wr_t           wr_q;

  logic              pix, proto_err, frame_err, good;
  logic [Y_W-1:0]    y_le;
  logic              bad_le;
  logic [1:0]        err_inc;

  vga_sync_edge #(.POL(HSYNC_POL)) u_hs (
    .clk     (clk),
    .rst     (rst),
    .sync_in (hsync),
    .act     (hs_act),
    .start   (hs_start)
  );

  vga_sync_edge #(.POL(VSYNC_POL)) u_vs (
    .clk     (clk),
    .rst     (rst),
    .sync_in (vsync),
    .act     (vs_act),
    .start   (vs_start)
  );

  // Input stage for valid and colour, aligned with the registered syncs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= 1'b0;
      rgb_q <= '0;
    end else begin
      v_q   <= blank_n;
      rgb_q <= {vga_r, vga_g, vga_b};
    end
  end

  // Line-end result first, so a coincident frame end sees the updated row.
  // A valid cycle inside a sync pulse is only a protocol error: it is not
  // counted as a pixel, so one glitch does not also wreck the geometry.
  always_comb begin
    pix       = v_q && !hs_act && !vs_act;
    proto_err = v_q && (hs_act || vs_act);
    y_le      = y;
    bad_le    = line_bad;
    if (hs_start && line_act) begin
      if (y != {Y_W{1'b1}}) y_le = y + 1'b1;
      if (x != H_ACT_X)     bad_le = 1'b1;
    end
    good      = (y_le == V_ACT_Y) && !bad_le;
    frame_err = vs_start && !good && (state != SEEK);
    err_inc   = {1'b0, proto_err} + {1'b0, frame_err};
  end

  // Geometry measurement: column/row counters, line activity and line length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      line_act  <= 1'b0;
      line_bad  <= 1'b0;
      clk_cnt   <= '0;
      line_clks <= '0;
    end else begin
      if (hs_start) begin
        line_clks <= clk_cnt;
        clk_cnt   <= LCLK_W'(1);
      end else if (clk_cnt != {LCLK_W{1'b1}}) begin
        clk_cnt   <= clk_cnt + 1'b1;
      end

      if (vs_start) begin
        x        <= '0;
        y        <= '0;
        line_bad <= 1'b0;
      end else if (hs_start) begin
        x        <= '0;
        y        <= y_le;
        line_bad <= bad_le;
      end else if (pix && (x != {X_W{1'b1}})) begin
        x        <= x + 1'b1;
      end

      if (hs_start)  line_act <= 1'b0;
      else if (pix)  line_act <= 1'b1;
    end
  end

  // Lock FSM with registered locked/frame_done and saturating error count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEEK;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      err_cnt    <= err_add(err_cnt, err_inc);
      if (vs_start) begin
        unique case (state)
          SEEK: begin
            state  <= TRAIN;
            locked <= 1'b0;
          end
          TRAIN: begin
            if (good) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (good) begin
              frame_done <= 1'b1;
            end else begin
              state  <= TRAIN;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEEK;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Write port: pre-increment coordinates of in-bounds pixels while locked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
    end else begin
      wr_q.en   <= (state == LOCKED) && pix && (x < H_ACT_X) && (y < V_ACT_Y);
      wr_q.x    <= x;
      wr_q.y    <= y;
      wr_q.data <= rgb_q;
    end
  end

  assign wr_en   = wr_q.en;
  assign wr_x    = wr_q.x;
  assign wr_y    = wr_q.y;
  assign wr_data = wr_q.data;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiving end of the team's VGA output interface: it takes hsync, vsync, blank_n (valid) and 24-bit RGB, exactly as driven by the display path.
- It recovers pixel coordinates and locks onto frame geometry.
- In lock, it emits a pixel write port for a frame buffer or scoreboard.
- It is the self-check block for the display pipeline in simulation and on board.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- HSYNC_POL, 0, asserted level of hsync (0 = active-low pulse)
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- hsync  input  1  horizontal sync
- vsync  input  1  vertical sync
- blank_n  input  1  pixel valid (1 = active video)
- vga_r  input  8  red
- vga_g  input  8  green
- vga_b  input  8  blue
- wr_en  output  1  pixel write strobe
- wr_x  output  10  pixel column
- wr_y  output  9  pixel row
- wr_data  output  24  {r,g,b}
- frame_done  output  1  one-cycle pulse at the end of each locked frame
- locked  output  1  geometry lock
- line_clks  output  12  clocks in the last complete line
- err_cnt  output  8  saturating protocol-error count

Behaviour:
- Reset (rst=0, async): all outputs 0; state SEEK; all counters 0.
- Input stage: every input is registered once. Edge detection works on the registered values against a second delayed copy.
- hs_start / vs_start: transition of the registered sync signal into its asserted level (set by HSYNC_POL / VSYNC_POL).
- Column counter x:
  - Cleared on hs_start.
  - Increments on each registered valid cycle.
  - Saturates at 1023.
- Line activity: line_act is set by any valid cycle in the line.
- Line end (hs_start):
  - If line_act: y increments (saturates at 511).
  - If line_act and x != H_ACTIVE: line_bad is set.
  - line_clks is loaded with the clock count since the previous hs_start (saturates at 4095).
  - line_act is cleared.
- Frame end (vs_start):
  - Frame is good when y == V_ACTIVE and line_bad == 0.
  - Afterwards y, x and line_bad are cleared.
- Simultaneous hs_start and vs_start: line end is evaluated first, then frame end sees the updated y.
- FSM:
  - SEEK: ignore data. On vs_start -> TRAIN.
  - TRAIN: measure only, no writes. On vs_start: good frame -> LOCKED; bad frame -> stay in TRAIN and increment err_cnt.
  - LOCKED: writes enabled. On vs_start: good frame -> pulse frame_done and stay; bad frame -> TRAIN, increment err_cnt, no frame_done.
- locked = (state == LOCKED). It drops the cycle after the bad vs_start is registered.
- Write port:
  - wr_en, wr_x, wr_y and wr_data are registered.
  - Latency is 2 clk from the input pins to the write port.
  - wr_en=1 only in LOCKED, for a registered valid pixel with x < H_ACTIVE and y < V_ACTIVE.
  - wr_x/wr_y are the pre-increment coordinates.
  - Pixels beyond the bounds are dropped silently; the frame check catches them.
- Valid asserted while hsync or vsync is asserted: err_cnt increments once per cycle. No FSM change.
- err_cnt saturates at 255 and is cleared only by reset.
- Reset mid-frame: immediate return to SEEK; the next write occurs no earlier than two vs_start events later.

Decomposition:
- Shared package vga_pkg, holding:
  - Default timing constants: H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525.
  - State encoding: SEEK / TRAIN / LOCKED.
  - RGB packing width (24).
- One natural sub-module, vga_sync_edge: registers a sync input and emits the start pulse per the polarity parameter. It is instantiated twice.

Test Plan:
- Drive the team's 640x480 display timing (800x525) from reset.
  - locked rises after the 2nd vs_start.
  - 3rd frame gives 307200 wr_en pulses and one frame_done.
  - line_clks = 800.
- Ramp pattern with data = {x[7:0], y[7:0], 8'h5A}.
  - First write is wr_x=0, wr_y=0, wr_data=24'h00005A.
  - Last write is wr_x=639, wr_y=479.
  - Each write occurs 2 clk after the input pixel.
- In a locked frame, shorten line 100 to 639 valid pixels.
  - No frame_done.
  - locked falls after that frame's vs_start and err_cnt = 1.
  - Lock recovers after one clean frame.
- Assert blank_n for 3 cycles inside the hsync pulse -> err_cnt += 3 and locked stays 1.
- Pull rst low mid-frame at line 200 -> outputs 0 asynchronously; no wr_en before the 2nd subsequent vs_start.
- Set HSYNC_POL=1 and VSYNC_POL=1 with inverted syncs -> identical results to the first scenario.
